// File: rtl/fcore_seq_pkg.sv
// Shared types and constants for the fCore run sequencer.
package fcore_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRunPulse,
      StWaitCore,
      StStartMover,
      StWaitMover
   } seq_state_t;

   localparam int unsigned DefaultTimeoutCycles = 4096;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating up-counter with synchronous clear.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             incr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (incr && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fcore_run_sequencer.sv
// Per-trigger fCore round sequencer: run pulse, wait done, start mover, wait last beat.
// Optional FCORE_SEQ_PENDING_TRIGGER_EN queues one trigger that arrives while busy.
module fcore_run_sequencer
   import fcore_seq_pkg::*;
#(
   parameter int unsigned RUN_PULSE_WIDTH = 5,
   parameter int unsigned TIMEOUT_CYCLES  = DefaultTimeoutCycles,
   parameter int unsigned COUNTER_WIDTH   = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     trigger,
   output logic                     core_run,
   input  logic                     core_done,
   output logic                     mover_start,
   input  logic                     mover_last,
   output logic                     busy,
   output logic                     overrun,
   output logic                     timeout,
   output logic [COUNTER_WIDTH-1:0] overrun_count,
   output logic [COUNTER_WIDTH-1:0] timeout_count
);

   seq_state_t  state_q, state_d;
   logic [3:0]  pulse_cnt_q, pulse_cnt_d;
   logic [15:0] wdog_q, wdog_d;
   logic        done_q;
   logic        overrun_q, timeout_q;
   logic        in_wait, done_rise, pulse_last, wdog_expired;
   logic        trig_en, trig_busy, start_req, overrun_hit, wdog_abort;

   assign done_rise    = core_done & ~done_q;
   assign pulse_last   = (pulse_cnt_q == 4'(RUN_PULSE_WIDTH - 1));
   assign wdog_expired = (wdog_q == 16'(TIMEOUT_CYCLES - 1));
   assign in_wait      = (state_q == StWaitCore) || (state_q == StWaitMover);
   assign trig_en      = trigger & enable;
   assign trig_busy    = trig_en & (state_q != StIdle);

`ifdef FCORE_SEQ_PENDING_TRIGGER_EN
   logic pend_q, pend_d;

   assign start_req   = trig_en | pend_q;
   assign overrun_hit = trig_busy & pend_q;

   // Abort and launch both consume the queued trigger.
   always_comb begin
      pend_d = pend_q;
      if (wdog_abort || ((state_q == StIdle) && pend_q)) begin
         pend_d = 1'b0;
      end else if (trig_busy) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end
`else
   assign start_req   = trig_en;
   assign overrun_hit = trig_busy;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Exit conditions are tested before watchdog expiry so they win a tie.
   always_comb begin
      state_d    = state_q;
      wdog_abort = 1'b0;
      unique case (state_q)
         StIdle:       if (start_req) state_d = StRunPulse;
         StRunPulse:   if (pulse_last) state_d = StWaitCore;
         StWaitCore: begin
            if (done_rise) begin
               state_d = StStartMover;
            end else if (wdog_expired) begin
               state_d    = StIdle;
               wdog_abort = 1'b1;
            end
         end
         StStartMover: state_d = StWaitMover;
         StWaitMover: begin
            if (mover_last) begin
               state_d = StIdle;
            end else if (wdog_expired) begin
               state_d    = StIdle;
               wdog_abort = 1'b1;
            end
         end
         default:      state_d = StIdle;
      endcase
   end

   always_comb begin
      core_run    = (state_q == StRunPulse);
      mover_start = (state_q == StStartMover);
      busy        = (state_q != StIdle);
      overrun     = overrun_q;
      timeout     = timeout_q;
   end

   always_comb begin
      pulse_cnt_d = (state_q == StRunPulse) ? pulse_cnt_q + 4'd1 : 4'd0;
      wdog_d      = (in_wait && (state_d == state_q)) ? wdog_q + 16'd1 : 16'd0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pulse_cnt_q <= 4'd0;
         wdog_q      <= 16'd0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         pulse_cnt_q <= pulse_cnt_d;
         wdog_q      <= wdog_d;
         done_q      <= core_done;
         overrun_q   <= overrun_hit;
         timeout_q   <= wdog_abort;
      end
   end

   sat_counter #(
      .WIDTH (COUNTER_WIDTH)
   ) u_overrun_cnt (
      .clock (clock),
      .reset (reset),
      .clear (1'b0),
      .incr  (overrun_hit),
      .count (overrun_count)
   );

   sat_counter #(
      .WIDTH (COUNTER_WIDTH)
   ) u_timeout_cnt (
      .clock (clock),
      .reset (reset),
      .clear (1'b0),
      .incr  (wdog_abort),
      .count (timeout_count)
   );

endmodule

// File: tb/tb_fcore_run_sequencer.sv
// Directed bench for fcore_run_sequencer (RUN_PULSE_WIDTH=5, TIMEOUT_CYCLES=100, COUNTER_WIDTH=4).
module tb_fcore_run_sequencer;

   localparam int unsigned CW = 4;

   logic          clock, reset, enable, trigger, core_done, mover_last;
   logic          core_run, mover_start, busy, overrun, timeout;
   logic [CW-1:0] overrun_count, timeout_count;
   logic [4:0]    exp_v;
   int            checks, errors;

   fcore_run_sequencer #(
      .RUN_PULSE_WIDTH (5),
      .TIMEOUT_CYCLES  (100),
      .COUNTER_WIDTH   (CW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .trigger       (trigger),
      .core_run      (core_run),
      .core_done     (core_done),
      .mover_start   (mover_start),
      .mover_last    (mover_last),
      .busy          (busy),
      .overrun       (overrun),
      .timeout       (timeout),
      .overrun_count (overrun_count),
      .timeout_count (timeout_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset      = 1'b1;
      enable     = 1'b1;
      trigger    = 1'b0;
      core_done  = 1'b0;
      mover_last = 1'b0;
      #2;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      enable     = 1'b1;
      trigger    = 1'b1;
      core_done  = 1'b1;
      mover_last = 1'b1;
      #2;
      checks++;
      if ({core_run, mover_start, busy, overrun, timeout} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b exp 00000",
                  {core_run, mover_start, busy, overrun, timeout});
      end
      tick();
      tick();
      checks++;
      if ({overrun_count, timeout_count, core_run, busy} !== '0) begin
         errors++;
         $display("FAIL reset_counters got ovr=%0d to=%0d run=%b busy=%b exp all 0",
                  overrun_count, timeout_count, core_run, busy);
      end
      apply_reset();
   endtask

   // Trigger at c=0, done rises at 30, last beat at 40.
   task automatic test_single_round();
      apply_reset();
      for (int c = 0; c <= 45; c++) begin
         trigger    = (c == 0);
         core_done  = (c >= 30);
         mover_last = (c == 40);
         exp_v = {(c >= 1 && c <= 5), (c == 31), (c >= 1 && c <= 40), 1'b0, 1'b0};
         checks++;
         if ({core_run, mover_start, busy, overrun, timeout} !== exp_v) begin
            errors++;
            $display("FAIL single_round c=%0d got run/start/busy/ovr/to=%b exp %b", c,
                     {core_run, mover_start, busy, overrun, timeout}, exp_v);
         end
         tick();
      end
      checks++;
      if (overrun_count !== 4'd0 || timeout_count !== 4'd0) begin
         errors++;
         $display("FAIL single_round_counts got ovr=%0d to=%0d exp 0 0",
                  overrun_count, timeout_count);
      end
   endtask

   task automatic test_overrun();
      logic exp_run, exp_busy, exp_ovr;
      apply_reset();
      for (int c = 0; c <= 50; c++) begin
         trigger    = (c == 0) || (c == 10);
         core_done  = (c >= 30);
         mover_last = (c == 40);
`ifdef FCORE_SEQ_PENDING_TRIGGER_EN
         exp_run  = (c >= 1 && c <= 5) || (c >= 42 && c <= 46);
         exp_busy = (c >= 1 && c <= 40) || (c >= 42);
         exp_ovr  = 1'b0;
`else
         exp_run  = (c >= 1 && c <= 5);
         exp_busy = (c >= 1 && c <= 40);
         exp_ovr  = (c == 11);
`endif
         checks++;
         if ({core_run, busy, overrun} !== {exp_run, exp_busy, exp_ovr}) begin
            errors++;
            $display("FAIL overrun c=%0d got run/busy/ovr=%b exp %b", c,
                     {core_run, busy, overrun}, {exp_run, exp_busy, exp_ovr});
         end
         tick();
      end
      checks++;
`ifdef FCORE_SEQ_PENDING_TRIGGER_EN
      if (overrun_count !== 4'd0) begin
         errors++;
         $display("FAIL overrun_count got %0d exp 0", overrun_count);
      end
`else
      if (overrun_count !== 4'd1) begin
         errors++;
         $display("FAIL overrun_count got %0d exp 1", overrun_count);
      end
`endif
   endtask

   // WAIT_CORE entered at c=6; expiry observed at c=106.
   task automatic test_core_timeout();
      apply_reset();
      for (int c = 0; c <= 110; c++) begin
         trigger = (c == 0);
         exp_v = {(c >= 1 && c <= 5), 1'b0, (c >= 1 && c <= 105), 1'b0, (c == 106)};
         checks++;
         if ({core_run, mover_start, busy, overrun, timeout} !== exp_v) begin
            errors++;
            $display("FAIL core_timeout c=%0d got run/start/busy/ovr/to=%b exp %b", c,
                     {core_run, mover_start, busy, overrun, timeout}, exp_v);
         end
         tick();
      end
      checks++;
      if (timeout_count !== 4'd1) begin
         errors++;
         $display("FAIL timeout_count got %0d exp 1", timeout_count);
      end
   endtask

   // done held high across entry; new edge at 25; last beat lands on watchdog expiry (c=126).
   task automatic test_done_held_and_tie();
      apply_reset();
      core_done = 1'b1;
      tick();
      tick();
      for (int c = 0; c <= 130; c++) begin
         trigger    = (c == 0);
         core_done  = (c < 20) || (c >= 25);
         mover_last = (c == 126);
         exp_v = {(c >= 1 && c <= 5), (c == 26), (c >= 1 && c <= 126), 1'b0, 1'b0};
         checks++;
         if ({core_run, mover_start, busy, overrun, timeout} !== exp_v) begin
            errors++;
            $display("FAIL done_held_tie c=%0d got run/start/busy/ovr/to=%b exp %b", c,
                     {core_run, mover_start, busy, overrun, timeout}, exp_v);
         end
         tick();
      end
      checks++;
      if (timeout_count !== 4'd0) begin
         errors++;
         $display("FAIL tie_timeout_count got %0d exp 0", timeout_count);
      end
   endtask

   task automatic test_enable();
      apply_reset();
      for (int c = 0; c <= 30; c++) begin
         enable     = (c >= 2 && c < 8);
         trigger    = (c == 0) || (c == 2) || (c == 8);
         core_done  = (c >= 20);
         mover_last = (c == 25);
         exp_v = {(c >= 3 && c <= 7), (c == 21), (c >= 3 && c <= 25), 1'b0, 1'b0};
         checks++;
         if ({core_run, mover_start, busy, overrun, timeout} !== exp_v) begin
            errors++;
            $display("FAIL enable c=%0d got run/start/busy/ovr/to=%b exp %b", c,
                     {core_run, mover_start, busy, overrun, timeout}, exp_v);
         end
         tick();
      end
      enable = 1'b1;
   endtask

   // A trigger in the first idle cycle after the last beat starts the next round.
   task automatic test_back_to_back();
      apply_reset();
      for (int c = 0; c <= 47; c++) begin
         trigger    = (c == 0) || (c == 41);
         core_done  = (c >= 30 && c < 35);
         mover_last = (c == 40);
         exp_v = {(c >= 1 && c <= 5) || (c >= 42 && c <= 46), (c == 31),
                  (c >= 1 && c <= 40) || (c >= 42), 1'b0, 1'b0};
         checks++;
         if ({core_run, mover_start, busy, overrun, timeout} !== exp_v) begin
            errors++;
            $display("FAIL back_to_back c=%0d got run/start/busy/ovr/to=%b exp %b", c,
                     {core_run, mover_start, busy, overrun, timeout}, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      logic [CW-1:0] exp_mid;
`ifdef FCORE_SEQ_PENDING_TRIGGER_EN
      exp_mid = 4'd8;
`else
      exp_mid = 4'd9;
`endif
      apply_reset();
      for (int c = 0; c <= 30; c++) begin
         trigger = (c <= 20) || (c >= 23 && c <= 26);
         if (c == 10) begin
            checks++;
            if (overrun_count !== exp_mid) begin
               errors++;
               $display("FAIL sat_mid got %0d exp %0d", overrun_count, exp_mid);
            end
         end
         if (c == 22 || c == 30) begin
            checks++;
            if (overrun_count !== 4'd15) begin
               errors++;
               $display("FAIL sat_hold c=%0d got %0d exp 15", c, overrun_count);
            end
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      checks++;
      if (core_run !== 1'b1) begin
         errors++;
         $display("FAIL async_pre got run=%b exp 1", core_run);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({core_run, busy, mover_start} !== 3'b000) begin
         errors++;
         $display("FAIL async_reset got run/busy/start=%b exp 000",
                  {core_run, busy, mover_start});
      end
      @(posedge clock);
      #1;
      reset   = 1'b0;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         checks++;
         if ({core_run, busy} !== {(c <= 5), 1'b1}) begin
            errors++;
            $display("FAIL async_restart c=%0d got run/busy=%b exp %b", c,
                     {core_run, busy}, {(c <= 5), 1'b1});
         end
         tick();
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      enable     = 1'b0;
      trigger    = 1'b0;
      core_done  = 1'b0;
      mover_last = 1'b0;
      test_reset();
      test_single_round();
      test_overrun();
      test_core_timeout();
      test_done_held_and_tie();
      test_enable();
      test_back_to_back();
      test_saturation();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
